data_mem_resp: RTL and testbench
================================

Name: data_mem_resp

Overview:
Data-memory responder at the far end of the CPU data-memory port. It answers word reads and writes from the bus interface unit over the shared 32-bit bidirectional data bus. A cycle is addressed by dMem_addr and qualified by chip-select and read/write strobes. A programmable wait-state FSM sequences each access and signals completion with a ready/error handshake. Backing store is an internal big-endian byte array.

Parameters:
DEPTH, 4096, size of the byte array; must be a power of two and at least 4.
WAIT_STATES, 2, number of wait cycles between accepting a request and acknowledging it; 0 to 15 allowed.

Ports:
Clk  in  1  system clock; all state changes on the rising edge.
Reset  in  1  asynchronous, active-low reset.
dMem_addr  in  32  byte address of the access.
Bus_data  inout  32  shared data bus; this block drives it only during a read acknowledge and is hi-Z otherwise.
dm_cs  in  1  chip select; an access is active while high.
dm_rd  in  1  read strobe.
dm_wr  in  1  write strobe.
dm_rdy  out  1  access complete; held high until the initiator drops its strobe.
dm_err  out  1  access rejected; same timing as dm_rdy.

Behaviour:
- Reset low, asynchronous: state=IDLE, dm_rdy=0, dm_err=0, Bus_data hi-Z, wait counter=0, latched address/data/direction=0. Memory contents are not cleared.
- Reset asserted mid-access: any write not yet committed is dropped. The block returns to IDLE immediately.
- States: IDLE, WAIT, ACK, FAULT.
- IDLE accepts a request when dm_cs=1 and exactly one of dm_rd/dm_wr is 1. On acceptance it latches:
  - dMem_addr;
  - direction;
  - Bus_data, for writes only.
- Acceptance check, on the latched address:
  - addr[1:0]!=0 (misaligned) or addr>=DEPTH (out of range): go to FAULT. No array access.
  - Otherwise, with WAIT_STATES>0: go to WAIT with counter=WAIT_STATES-1.
  - Otherwise (WAIT_STATES=0): go directly to ACK.
- dm_cs=1 with dm_rd=dm_wr=1 in IDLE is a protocol error: go to FAULT.
- WAIT: decrement the counter each cycle. When it reaches 0, go to ACK on the next edge.
- Total latency from acceptance edge to dm_rdy high is WAIT_STATES+1 edges.
- Write commit: on the edge entering ACK, bytes are written big-endian:
  - M[a] = data[31:24]
  - M[a+1] = data[23:16]
  - M[a+2] = data[15:8]
  - M[a+3] = data[7:0]
- Read data: captured on the edge entering ACK as {M[a],M[a+1],M[a+2],M[a+3]}.
- ACK: dm_rdy=1 (registered).
  - Bus_data is driven with the captured word only while state=ACK, direction=read, dm_cs=1 and dm_rd=1. This is combinational, so the drive releases in the same cycle the strobe falls and there is no bus contention.
- FAULT: dm_err=1 (registered) and dm_rdy=0. Bus_data is never driven.
- Exit from ACK or FAULT: on the first edge where dm_cs=0, or where the strobe that started the access is 0, return to IDLE. dm_rdy and dm_err clear on that edge.
  - A new request needs at least one IDLE cycle; back-to-back requests without a gap are not accepted from ACK or FAULT.
- Strobe changes during WAIT:
  - Strobe or chip-select dropped during WAIT: the access completes internally (a write still commits). ACK is then left on the next edge.
  - dm_rd/dm_wr changes during WAIT are ignored; the direction was latched at acceptance.
- Address wrap: none. a+3 never exceeds DEPTH-1 because the access is aligned and range-checked.
- dm_rdy and dm_err are never high together.

Test Plan:
- Reset with WAIT_STATES=2: dm_rdy=0, dm_err=0, Bus_data=Z. Write 0xDEADBEEF to addr 0x10 → dm_rdy rises on the 3rd edge after acceptance. Read addr 0x10 → Bus_data=0xDEADBEEF while dm_rd is high, then Z the cycle dm_rd falls.
- Byte order: write 0x11223344 to 0x20, then read 0x20 → 0x11223344. Internal bytes M[0x20..0x23]=11,22,33,44.
- Misaligned read at 0x22 → dm_err=1 on the next edge, dm_rdy=0, bus stays Z. Out-of-range write at DEPTH (0x1000) → dm_err=1, memory unchanged.
- dm_cs=1 with dm_rd=dm_wr=1 → FAULT, dm_err=1. Drop dm_cs → IDLE next edge, dm_err=0.
- WAIT_STATES=0: write then read addr 0x4 → dm_rdy is high one edge after acceptance, read returns the written value. Request held through ACK is not re-accepted until one IDLE cycle has passed.
- Write 0xCAFEF00D to 0x8 and assert Reset low during WAIT → outputs clear immediately. After release, read 0x8 → prior contents (the write was not committed).

Source files
------------

// File: rtl/data_mem_resp.sv
// Data-memory responder: word reads/writes over a shared tri-state bus,
// with a programmable wait-state sequence and a ready/error handshake.
`timescale 1ns/1ps
module data_mem_resp #(
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] dMem_addr,
  inout  wire  [31:0] Bus_data,
  input  logic        dm_cs,
  input  logic        dm_rd,
  input  logic        dm_wr,
  output logic        dm_rdy,
  output logic        dm_err
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned WAW = (AW > 2) ? AW - 2 : 1;
  localparam int unsigned CW  = 4;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ACK   = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WAW-1:0]   widx_q, widx_d;
  logic [31:0]      data_q, data_d;
  logic             dir_q, dir_d;
  logic [31:0]      rdata_q;
  logic             enter_ack_c;
  logic             strobe_held_c;

  logic [7:0] mem [DEPTH];

  // The strobe that opened the access must stay high to hold ACK/FAULT.
  assign strobe_held_c = dm_cs && (dir_q ? dm_rd : dm_wr);

  // Next-state, request latching and wait-state counting.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    widx_d      = widx_q;
    data_d      = data_q;
    dir_d       = dir_q;
    enter_ack_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dm_cs && (dm_rd || dm_wr)) begin
          widx_d = dMem_addr[WAW+1:2];
          dir_d  = dm_rd;
          if (dm_wr && !dm_rd) begin
            data_d = Bus_data;
          end
          if (dm_rd && dm_wr) begin
            state_d = S_FAULT;
          end else if ((dMem_addr[1:0] != 2'b00) || (dMem_addr >= 32'(DEPTH))) begin
            state_d = S_FAULT;
          end else if (WAIT_STATES != 0) begin
            state_d = S_WAIT;
            cnt_d   = CW'(WAIT_STATES - 1);
          end else begin
            state_d     = S_ACK;
            enter_ack_c = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = S_ACK;
          enter_ack_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_ACK, S_FAULT: begin
        if (!strobe_held_c) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, latched request and handshake outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      data_q  <= '0;
      dir_q   <= 1'b0;
      rdata_q <= '0;
      dm_rdy  <= 1'b0;
      dm_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      dm_rdy  <= (state_d == S_ACK);
      dm_err  <= (state_d == S_FAULT);
      if (enter_ack_c && dir_d) begin
        rdata_q <= {mem[{widx_d, 2'b00}], mem[{widx_d, 2'b01}],
                    mem[{widx_d, 2'b10}], mem[{widx_d, 2'b11}]};
      end
    end
  end

  // Big-endian write commit on the edge that enters ACK; contents survive reset.
  always_ff @(posedge Clk) begin
    if (enter_ack_c && !dir_d) begin
      mem[{widx_d, 2'b00}] <= data_d[31:24];
      mem[{widx_d, 2'b01}] <= data_d[23:16];
      mem[{widx_d, 2'b10}] <= data_d[15:8];
      mem[{widx_d, 2'b11}] <= data_d[7:0];
    end
  end

  // Drive releases combinationally as soon as the read strobe or select drops.
  assign Bus_data = ((state_q == S_ACK) && dir_q && dm_cs && dm_rd) ? rdata_q : {32{1'bz}};

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: table vectors, corner sequences
// and randomized accesses against a byte-array reference model.
`timescale 1ns/1ps
module tb_data_mem_resp;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [1:0]  cs;
  logic        rd, wr;
  logic [31:0] drv;
  logic [1:0]  drv_en;
  logic [1:0]  rdy, err;
  wire  [31:0] bus2;
  wire  [31:0] bus0;

  int checks   = 0;
  int failures = 0;

  localparam int unsigned WS_A = 2;
  localparam int unsigned DEP_A = 4096;
  localparam int unsigned WS_B = 0;
  localparam int unsigned DEP_B = 256;
  localparam logic [31:0] FLOAT = 32'hFFFF_FFFF;

  data_mem_resp #(.DEPTH(DEP_A), .WAIT_STATES(WS_A)) u_ws2 (
    .Clk(clk), .Reset(rst_n), .dMem_addr(addr), .Bus_data(bus2),
    .dm_cs(cs[0]), .dm_rd(rd), .dm_wr(wr), .dm_rdy(rdy[0]), .dm_err(err[0]));

  data_mem_resp #(.DEPTH(DEP_B), .WAIT_STATES(WS_B)) u_ws0 (
    .Clk(clk), .Reset(rst_n), .dMem_addr(addr), .Bus_data(bus0),
    .dm_cs(cs[1]), .dm_rd(rd), .dm_wr(wr), .dm_rdy(rdy[1]), .dm_err(err[1]));

  assign bus2 = drv_en[0] ? drv : {32{1'bz}};
  assign bus0 = drv_en[1] ? drv : {32{1'bz}};

  // Pull-ups make an undriven bus read back as all ones.
  for (genvar i = 0; i < 32; i++) begin : g_pu
    pullup (bus2[i]);
    pullup (bus0[i]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic int unsigned ws_of(input int inst);
    return (inst == 0) ? WS_A : WS_B;
  endfunction

  function automatic int unsigned dep_of(input int inst);
    return (inst == 0) ? DEP_A : DEP_B;
  endfunction

  function automatic logic [31:0] bus_of(input int inst);
    return (inst == 0) ? bus2 : bus0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One complete access: request, bounded wait for handshake, release, back to idle.
  task automatic access(input int inst, input bit is_rd, input logic [31:0] a,
                        input logic [31:0] wd, input bit exp_err,
                        input logic [31:0] exp_rd, input string name);
    int lat;
    bit done;
    int unsigned exp_lat;
    @(negedge clk);
    addr = a;
    cs[inst] = 1'b1;
    rd = is_rd;
    wr = !is_rd;
    if (!is_rd) begin
      drv = wd;
      drv_en[inst] = 1'b1;
    end
    lat = 0;
    done = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (rdy[inst] || err[inst]) done = 1'b1;
    end
    exp_lat = exp_err ? 1 : ws_of(inst) + 1;
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_rdy"}, 32'(rdy[inst]), 32'(!exp_err));
    chk({name, "_err"}, 32'(err[inst]), 32'(exp_err));
    if (is_rd) begin
      chk({name, "_bus"}, bus_of(inst), exp_err ? FLOAT : exp_rd);
    end
    @(negedge clk);
    cs = '0;
    rd = 1'b0;
    wr = 1'b0;
    drv_en = '0;
    #1;
    if (is_rd) chk({name, "_release"}, bus_of(inst), FLOAT);
    @(posedge clk);
    #1;
    chk({name, "_idle"}, {30'd0, rdy[inst], err[inst]}, 32'd0);
  endtask

  typedef struct {
    int          inst;
    bit          is_rd;
    logic [31:0] a;
    logic [31:0] d;
    bit          exp_err;
  } vec_t;

  vec_t vecs [14];

  logic [7:0]  mdl [int unsigned];
  logic [31:0] wq0 [$];
  logic [31:0] wq1 [$];

  initial begin
    addr = '0; cs = '0; rd = 1'b0; wr = 1'b0; drv = '0; drv_en = '0;
    rst_n = 1'b0;

    vecs[0]  = '{0, 1'b0, 32'h10,   32'hDEAD_BEEF, 1'b0};
    vecs[1]  = '{0, 1'b1, 32'h10,   32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{0, 1'b0, 32'h20,   32'h1122_3344, 1'b0};
    vecs[3]  = '{0, 1'b1, 32'h20,   32'h1122_3344, 1'b0};
    vecs[4]  = '{0, 1'b1, 32'h22,   32'h0,         1'b1};
    vecs[5]  = '{0, 1'b0, 32'h1000, 32'h5555_AAAA, 1'b1};
    vecs[6]  = '{0, 1'b1, 32'h10,   32'hDEAD_BEEF, 1'b0};
    vecs[7]  = '{1, 1'b0, 32'h4,    32'hA5A5_0F0F, 1'b0};
    vecs[8]  = '{1, 1'b1, 32'h4,    32'hA5A5_0F0F, 1'b0};
    vecs[9]  = '{1, 1'b0, 32'hFC,   32'h0BAD_C0DE, 1'b0};
    vecs[10] = '{1, 1'b1, 32'hFC,   32'h0BAD_C0DE, 1'b0};
    vecs[11] = '{1, 1'b0, 32'h100,  32'h1234_5678, 1'b1};
    vecs[12] = '{1, 1'b1, 32'hFD,   32'h0,         1'b1};
    vecs[13] = '{0, 1'b1, 32'hFFC,  32'h0,         1'b1};
    vecs[13].is_rd = 1'b0;
    vecs[13].d = 32'h0F1E_2D3C;
    vecs[13].exp_err = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_rdy", 32'(rdy[i]), 32'd0);
      chk("reset_err", 32'(err[i]), 32'd0);
      chk("reset_bus", bus_of(i), FLOAT);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      access(vecs[i].inst, vecs[i].is_rd, vecs[i].a, vecs[i].d, vecs[i].exp_err,
             vecs[i].d, $sformatf("vec%0d", i));
    end
    access(0, 1'b1, 32'hFFC, 32'h0, 1'b0, 32'h0F1E_2D3C, "vec_last_word");
    chk("byte_20", 32'(u_ws2.mem[32'h20]), 32'h11);
    chk("byte_21", 32'(u_ws2.mem[32'h21]), 32'h22);
    chk("byte_22", 32'(u_ws2.mem[32'h22]), 32'h33);
    chk("byte_23", 32'(u_ws2.mem[32'h23]), 32'h44);

    // Both strobes high is a protocol fault; dropping select returns to idle.
    @(negedge clk);
    addr = 32'h40; cs[0] = 1'b1; rd = 1'b1; wr = 1'b1;
    @(posedge clk); #1;
    chk("both_err", 32'(err[0]), 32'd1);
    chk("both_rdy", 32'(rdy[0]), 32'd0);
    chk("both_bus", bus2, FLOAT);
    @(negedge clk);
    cs = '0;
    @(posedge clk); #1;
    chk("both_clear", 32'(err[0]), 32'd0);
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;

    // Held read in ACK with zero wait states; strobe swap needs an idle cycle.
    @(negedge clk);
    addr = 32'h4; cs[1] = 1'b1; rd = 1'b1;
    @(posedge clk); #1;
    chk("hold_rdy0", 32'(rdy[1]), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("hold_rdy2", 32'(rdy[1]), 32'd1);
    chk("hold_bus", bus0, 32'hA5A5_0F0F);
    @(negedge clk);
    rd = 1'b0; wr = 1'b1; drv = 32'h600D_F00D; drv_en[1] = 1'b1;
    @(posedge clk); #1;
    chk("b2b_gap", 32'(rdy[1]), 32'd0);
    @(posedge clk); #1;
    chk("b2b_accept", 32'(rdy[1]), 32'd1);
    @(negedge clk);
    cs = '0; wr = 1'b0; drv_en = '0;
    @(posedge clk);
    access(1, 1'b1, 32'h4, 32'h0, 1'b0, 32'h600D_F00D, "b2b_read");

    // Select dropped during WAIT: the write still commits, ACK lasts one cycle.
    @(negedge clk);
    addr = 32'h30; cs[0] = 1'b1; wr = 1'b1; drv = 32'h55AA_33CC; drv_en[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cs = '0; wr = 1'b0; drv_en = '0;
    @(posedge clk); #1;
    chk("drop_wait", 32'(rdy[0]), 32'd0);
    @(posedge clk); #1;
    chk("drop_ack", 32'(rdy[0]), 32'd1);
    @(posedge clk); #1;
    chk("drop_exit", 32'(rdy[0]), 32'd0);
    access(0, 1'b1, 32'h30, 32'h0, 1'b0, 32'h55AA_33CC, "drop_read");

    // Reset while in ACK clears the handshake and the bus drive at once.
    @(negedge clk);
    addr = 32'h10; cs[0] = 1'b1; rd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rstack_rdy_before", 32'(rdy[0]), 32'd1);
    chk("rstack_bus_before", bus2, 32'hDEAD_BEEF);
    #2 rst_n = 1'b0;
    #1;
    chk("rstack_rdy", 32'(rdy[0]), 32'd0);
    chk("rstack_bus", bus2, FLOAT);
    @(negedge clk);
    cs = '0; rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during WAIT drops the pending write.
    access(0, 1'b0, 32'h8, 32'h0102_0304, 1'b0, 32'h0, "pre8");
    @(negedge clk);
    addr = 32'h8; cs[0] = 1'b1; wr = 1'b1; drv = 32'hCAFE_F00D; drv_en[0] = 1'b1;
    @(posedge clk); #1;
    chk("rstwait_rdy", 32'(rdy[0]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstwait_out", {30'd0, rdy[0], err[0]}, 32'd0);
    @(negedge clk);
    cs = '0; wr = 1'b0; drv_en = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    access(0, 1'b1, 32'h8, 32'h0, 1'b0, 32'h0102_0304, "rstwait_read");

    // Randomized accesses against the byte-array model.
    for (int n = 0; n < 120; n++) begin
      int inst;
      int unsigned dep;
      int unsigned r;
      bit is_rd;
      logic [31:0] a, wd, exp_rd;
      bit exp_err;
      int unsigned qs;
      inst = n % 2;
      dep = dep_of(inst);
      qs = (inst == 0) ? wq0.size() : wq1.size();
      is_rd = (qs > 0) && ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 7);
      if (r == 0) begin
        a = 32'(4 * $urandom_range(0, dep / 4 - 1) + $urandom_range(1, 3));
      end else if (r == 1) begin
        a = ($urandom_range(0, 1) == 1) ? 32'(dep + 4 * $urandom_range(0, 15))
                                        : ($urandom() | 32'h8000_0000);
      end else if (is_rd) begin
        a = (inst == 0) ? wq0[$urandom_range(0, qs - 1)] : wq1[$urandom_range(0, qs - 1)];
      end else begin
        a = 32'(4 * $urandom_range(0, dep / 4 - 1));
      end
      wd = $urandom();
      if (wd == FLOAT) wd = 32'h0;
      exp_err = (a[1:0] != 2'b00) || (a >= 32'(dep));
      exp_rd = '0;
      if (!exp_err && is_rd) begin
        for (int b = 0; b < 4; b++) begin
          exp_rd = {exp_rd[23:0], mdl[(32'(inst) << 16) + a + 32'(b)]};
        end
      end
      access(inst, is_rd, a, wd, exp_err, exp_rd, $sformatf("rnd%0d", n));
      if (!exp_err && !is_rd) begin
        for (int b = 0; b < 4; b++) begin
          mdl[(32'(inst) << 16) + a + 32'(b)] = wd[31 - 8 * b -: 8];
        end
        if (inst == 0) wq0.push_back(a);
        else wq1.push_back(a);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
